// File: rtl/store_align_unit_pkg.sv
// Shared store-op encodings, FSM states and op-size helper for the store alignment unit.
package store_align_unit_pkg;

  localparam int STORE_OP_WIDTH = 3;

  localparam logic [STORE_OP_WIDTH-1:0] STORE_OP_SB = 3'd0;
  localparam logic [STORE_OP_WIDTH-1:0] STORE_OP_SH = 3'd1;
  localparam logic [STORE_OP_WIDTH-1:0] STORE_OP_SW = 3'd2;
  localparam logic [STORE_OP_WIDTH-1:0] STORE_OP_SD = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Access size in bytes; 0 marks an unknown op.
  function automatic logic [3:0] op_bytes(input logic [STORE_OP_WIDTH-1:0] op);
    case (op)
      STORE_OP_SB: op_bytes = 4'd1;
      STORE_OP_SH: op_bytes = 4'd2;
      STORE_OP_SW: op_bytes = 4'd4;
      STORE_OP_SD: op_bytes = 4'd8;
      default:     op_bytes = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_shifter.sv
// Combinational lane shifter: positions store data across two bus words and builds byte strobes.
module store_lane_shifter
  import store_align_unit_pkg::*;
#(
  parameter int DW = 32,
  localparam int NB = DW / 8,
  localparam int OW = $clog2(NB)
) (
  input  logic [OW-1:0]             off_i,
  input  logic [STORE_OP_WIDTH-1:0] op_i,
  input  logic [DW-1:0]             data_i,
  output logic [2*DW-1:0]           sh_o,
  output logic [2*NB-1:0]           st_o,
  output logic                      split_o,
  output logic                      misaligned_o,
  output logic                      illegal_o
);

  logic [3:0]      nbytes;
  logic [2*NB-1:0] lo_mask;
  logic [2*DW-1:0] sh_raw;
  logic [OW-1:0]   amask;

  assign nbytes       = op_bytes(op_i);
  assign illegal_o    = (nbytes == 4'd0) || (32'(nbytes) > NB);
  assign lo_mask      = ((2*NB)'(1) << nbytes) - (2*NB)'(1);
  assign st_o         = lo_mask << off_i;
  assign sh_raw       = {{DW{1'b0}}, data_i} << {off_i, 3'b000};
  assign amask        = OW'(nbytes - 4'd1);
  assign misaligned_o = |(off_i & amask);
  assign split_o      = |st_o[2*NB-1:NB];

  // Unused lanes are forced to zero so stray upper data bits never reach the bus.
  for (genvar i = 0; i < 2*NB; i++) begin : g_lane
    assign sh_o[8*i +: 8] = st_o[i] ? sh_raw[8*i +: 8] : 8'h00;
  end

endmodule

// File: rtl/store_align_unit.sv
// Store alignment unit: accepts a CPU store, issues one or two aligned bus beats, then pulses done.
// Optional macro STORE_ALIGN_SPLIT_EN allows misaligned stores (split across two beats when needed).
module store_align_unit
  import store_align_unit_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [AW-1:0]             req_addr,
  input  logic [STORE_OP_WIDTH-1:0] req_op,
  input  logic [DW-1:0]             req_data,
  output logic                      mem_valid,
  input  logic                      mem_ready,
  output logic [AW-1:0]             mem_addr,
  output logic [DW-1:0]             mem_wdata,
  output logic [DW/8-1:0]           mem_wstrb,
  output logic                      done,
  output logic                      fault
);

  localparam int NB = DW / 8;
  localparam int OW = $clog2(NB);

`ifdef STORE_ALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q, b1_wdata_q;
  logic [NB-1:0]   wstrb_q, b1_wstrb_q;
  logic            split_q, fault_q;

  logic [2*DW-1:0] sh;
  logic [2*NB-1:0] st;
  logic            split, misaligned, illegal;
  logic            accept, req_fault, beat_hs, to_beat1;

  store_lane_shifter #(.DW(DW)) u_shifter (
    .off_i        (req_addr[OW-1:0]),
    .op_i         (req_op),
    .data_i       (req_data),
    .sh_o         (sh),
    .st_o         (st),
    .split_o      (split),
    .misaligned_o (misaligned),
    .illegal_o    (illegal)
  );

  assign accept    = req_valid && req_ready;
  assign req_fault = illegal || (misaligned && !SPLIT_EN);
  assign beat_hs   = mem_valid && mem_ready;
  assign to_beat1  = (state_q == ST_BEAT0) && beat_hs && SPLIT_EN && split_q;

  assign req_ready = (state_q == ST_IDLE);
  assign mem_valid = (state_q == ST_BEAT0) || (state_q == ST_BEAT1);
  assign done      = (state_q == ST_RESP);
  assign fault     = (state_q == ST_RESP) && fault_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = req_fault ? ST_RESP : ST_BEAT0;
      ST_BEAT0: if (beat_hs) state_d = (SPLIT_EN && split_q) ? ST_BEAT1 : ST_RESP;
      ST_BEAT1: if (beat_hs) state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Beat registers only move on accept or on the beat0->beat1 handoff, so they hold during stalls.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      b1_wdata_q <= '0;
      b1_wstrb_q <= '0;
      split_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else if (accept) begin
      fault_q <= req_fault;
      if (!req_fault) begin
        addr_q     <= {req_addr[AW-1:OW], {OW{1'b0}}};
        wdata_q    <= sh[DW-1:0];
        wstrb_q    <= st[NB-1:0];
        b1_wdata_q <= sh[2*DW-1:DW];
        b1_wstrb_q <= st[2*NB-1:NB];
        split_q    <= split;
      end
    end else if (to_beat1) begin
      addr_q  <= addr_q + AW'(NB);
      wdata_q <= b1_wdata_q;
      wstrb_q <= b1_wstrb_q;
    end
  end

endmodule

// File: tb/tb_store_align_unit.sv
// Randomised self-checking bench for store_align_unit against a byte-level reference model.
module tb_store_align_unit;
  import store_align_unit_pkg::*;

`ifdef STORE_ALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic resetn;

  logic        req_valid, req_ready, mem_valid, mem_ready, done, fault;
  logic [31:0] req_addr, mem_addr, req_data, mem_wdata;
  logic [2:0]  req_op;
  logic [3:0]  mem_wstrb;

  logic        req_valid64, req_ready64, mem_valid64, mem_ready64, done64, fault64;
  logic [31:0] req_addr64, mem_addr64;
  logic [63:0] req_data64, mem_wdata64;
  logic [2:0]  req_op64;
  logic [7:0]  mem_wstrb64;

  store_align_unit #(.DW(32), .AW(32)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_op(req_op), .req_data(req_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .done(done), .fault(fault)
  );

  store_align_unit #(.DW(64), .AW(32)) dut64 (
    .clk(clk), .resetn(resetn), .req_valid(req_valid64), .req_ready(req_ready64),
    .req_addr(req_addr64), .req_op(req_op64), .req_data(req_data64),
    .mem_valid(mem_valid64), .mem_ready(mem_ready64), .mem_addr(mem_addr64),
    .mem_wdata(mem_wdata64), .mem_wstrb(mem_wstrb64), .done(done64), .fault(fault64)
  );

  int vectors = 0;
  int errors  = 0;

  // Reference model results: byte-by-byte placement of the store.
  bit          e_fault;
  int          e_n;
  logic [31:0] e_addr [2];
  logic [63:0] e_wd   [2];
  logic [7:0]  e_st   [2];

  function automatic void model(input logic [31:0] a, input logic [2:0] op,
                                input logic [63:0] d, input int nb);
    int n, lane, b;
    bit ill, mis;
    logic [31:0] base, ba, w;
    case (op)
      3'd0: n = 1;
      3'd1: n = 2;
      3'd2: n = 4;
      3'd3: n = 8;
      default: n = 0;
    endcase
    ill     = (n == 0) || (n > nb);
    mis     = (n != 0) && ((a % n) != 0);
    e_fault = ill || (mis && !SPLIT);
    e_n     = 0;
    for (int i = 0; i < 2; i++) begin
      e_addr[i] = '0; e_wd[i] = '0; e_st[i] = '0;
    end
    base = a & ~(32'(nb) - 32'd1);
    if (!e_fault) begin
      for (int k = 0; k < n; k++) begin
        ba   = a + 32'(k);
        w    = ba & ~(32'(nb) - 32'd1);
        lane = int'(ba % nb);
        b    = (w == base) ? 0 : 1;
        e_addr[b]             = w;
        e_wd[b][8*lane +: 8]  = d[8*k +: 8];
        e_st[b][lane]         = 1'b1;
        if (b + 1 > e_n) e_n = b + 1;
      end
    end
  endfunction

  // mode 0: mem_ready high; 1: random ready; 2: ready low for 5 beat cycles first
  task automatic run32(input logic [31:0] a, input logic [2:0] op, input logic [31:0] d, input int mode);
    int idx = 0, cyc, stall = 0;
    bit got_done = 0;
    model(a, op, {32'h0, d}, 4);
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL ready_idle act=%b exp=1", req_ready); end
    req_valid = 1'b1; req_addr = a; req_op = op; req_data = d;
    mem_ready = (mode == 0) ? 1'b1 : 1'(($urandom_range(0, 1)));
    @(negedge clk);
    req_valid = 1'b0; req_data = $urandom; req_addr = $urandom;
    cyc = 1;
    while (!got_done && cyc < 60) begin
      if (done === 1'b1) begin
        got_done = 1;
        vectors++;
        if (fault !== e_fault) begin errors++; $display("FAIL fault a=%h op=%0d act=%b exp=%b", a, op, fault, e_fault); end
        vectors++;
        if (idx !== e_n) begin errors++; $display("FAIL beat_count a=%h op=%0d act=%0d exp=%0d", a, op, idx, e_n); end
        if (mode == 0) begin
          vectors++;
          if (cyc !== e_n + 1) begin errors++; $display("FAIL latency a=%h act=%0d exp=%0d", a, cyc, e_n + 1); end
        end
        vectors++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL ready_in_resp act=%b exp=0", req_ready); end
      end else begin
        if (mem_valid === 1'b1) begin
          vectors++;
          if (idx >= e_n) begin
            errors++; $display("FAIL extra_beat a=%h op=%0d beat=%0d exp_beats=%0d", a, op, idx, e_n);
          end else if ({mem_addr, mem_wdata, mem_wstrb} !== {e_addr[idx], e_wd[idx][31:0], e_st[idx][3:0]}) begin
            errors++;
            $display("FAIL beat%0d a=%h act=%h/%h/%b exp=%h/%h/%b", idx, a, mem_addr, mem_wdata, mem_wstrb,
                     e_addr[idx], e_wd[idx][31:0], e_st[idx][3:0]);
          end
          case (mode)
            0:       mem_ready = 1'b1;
            1:       mem_ready = 1'($urandom_range(0, 1));
            default: begin mem_ready = (stall < 5) ? 1'b0 : 1'b1; stall++; end
          endcase
          if (mem_ready) idx++;
        end else begin
          mem_ready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        cyc++;
      end
    end
    if (!got_done) begin
      vectors++; errors++; $display("FAIL done_timeout a=%h op=%0d", a, op);
    end
    @(negedge clk);
    vectors++;
    if ({req_ready, done, mem_valid} !== 3'b100) begin
      errors++; $display("FAIL after_resp ready/done/valid act=%b exp=100", {req_ready, done, mem_valid});
    end
    mem_ready = 1'b1;
  endtask

  task automatic run64(input logic [31:0] a, input logic [2:0] op, input logic [63:0] d);
    int idx = 0, cyc;
    bit got_done = 0;
    model(a, op, d, 8);
    @(negedge clk);
    req_valid64 = 1'b1; req_addr64 = a; req_op64 = op; req_data64 = d; mem_ready64 = 1'b1;
    @(negedge clk);
    req_valid64 = 1'b0; req_data64 = {$urandom, $urandom};
    cyc = 1;
    while (!got_done && cyc < 20) begin
      if (done64 === 1'b1) begin
        got_done = 1;
        vectors++;
        if ({fault64, 32'(idx), 32'(cyc)} !== {e_fault, 32'(e_n), 32'(e_n + 1)})
          begin errors++; $display("FAIL dw64_done a=%h fault=%b/%b beats=%0d/%0d cyc=%0d", a, fault64, e_fault, idx, e_n, cyc); end
      end else begin
        if (mem_valid64 === 1'b1) begin
          vectors++;
          if (idx >= e_n) begin
            errors++; $display("FAIL dw64_extra_beat a=%h beat=%0d", a, idx);
          end else if ({mem_addr64, mem_wdata64, mem_wstrb64} !== {e_addr[idx], e_wd[idx], e_st[idx]}) begin
            errors++;
            $display("FAIL dw64_beat%0d a=%h act=%h/%h/%b exp=%h/%h/%b", idx, a, mem_addr64, mem_wdata64,
                     mem_wstrb64, e_addr[idx], e_wd[idx], e_st[idx]);
          end
          idx++;
        end
        @(negedge clk);
        cyc++;
      end
    end
    if (!got_done) begin
      vectors++; errors++; $display("FAIL dw64_timeout a=%h", a);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb, done, fault} !== {2'b10, 68'h0, 2'b00}) begin
      errors++;
      $display("FAIL reset_state act rdy=%b vld=%b a=%h d=%h s=%b done=%b fault=%b exp rdy=1 rest 0",
               req_ready, mem_valid, mem_addr, mem_wdata, mem_wstrb, done, fault);
    end
    resetn = 1'b1;
  endtask

  task automatic test_directed();
    run32(32'h100, STORE_OP_SW, 32'hDEADBEEF, 0);
    run32(32'h203, STORE_OP_SB, 32'h000000A5, 0);
    run32(32'h102, STORE_OP_SW, 32'h11223344, 0);
    run32(32'hFFFFFFFF, STORE_OP_SH, 32'h0000AABB, 0);
    run32(32'h201, STORE_OP_SH, 32'h0000CAFE, 0);
    run32(32'h300, STORE_OP_SD, 32'h12345678, 0);
    run32(32'h300, 3'd6, 32'h12345678, 0);
  endtask

  task automatic test_stall();
    run32(32'h104, STORE_OP_SW, 32'hA1B2C3D4, 2);
    run32(32'h107, STORE_OP_SH, 32'h00005566, 2);
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [2:0]  op;
    for (int i = 0; i < 150; i++) begin
      a  = $urandom;
      if ($urandom_range(0, 1) == 1) a = a & ~32'h3;
      op = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      run32(a, op, $urandom, 1);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_valid = 1'b1; req_addr = SPLIT ? 32'h102 : 32'h100; req_op = STORE_OP_SW; req_data = 32'h55667788;
    mem_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    mem_ready = SPLIT;
    @(negedge clk);
    mem_ready = 1'b0;
    vectors++;
    if (mem_valid !== 1'b1) begin errors++; $display("FAIL mid_valid_before_reset act=%b exp=1", mem_valid); end
    resetn = 1'b0;
    #1;
    vectors++;
    if (mem_valid !== 1'b0) begin errors++; $display("FAIL async_reset_valid act=%b exp=0", mem_valid); end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if ({done, mem_valid, req_ready} !== 3'b001) begin
        errors++; $display("FAIL post_reset done/valid/ready act=%b exp=001", {done, mem_valid, req_ready});
      end
    end
  endtask

  task automatic test_dw64();
    run64(32'h8, STORE_OP_SD, 64'h0123456789ABCDEF);
    run64(32'h13, STORE_OP_SB, 64'h00000000000000C3);
    run64(32'h24, STORE_OP_SW, 64'h00000000FEEDF00D);
    for (int i = 0; i < 20; i++)
      run64($urandom & ~32'h7, 3'($urandom_range(0, 3)), {$urandom, $urandom});
  endtask

  initial begin
    req_valid = 0; req_addr = 0; req_op = 0; req_data = 0; mem_ready = 1;
    req_valid64 = 0; req_addr64 = 0; req_op64 = 0; req_data64 = 0; mem_ready64 = 1;
    test_reset();
    test_directed();
    test_stall();
    test_random();
    test_reset_mid();
    test_dw64();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
